pool_layer: RTL and testbench

Layer-1 max-pooling stage downstream of the convolution/ReLU engine. After the convolution engine has filled the two 64×64 layer-0 result memories (one per kernel), this block reads each channel through the shared memory port. It reduces every non-overlapping 2×2 window to its maximum and writes the 32×32 pooled maps to the layer-1 memories. It reuses the same `csel`-multiplexed read/write port style as the convolution stage so the two can share the testbench memory model.

---
 rtl/pool_pkg.sv | 26 ++
 rtl/max_tracker.sv | 34 +++
 rtl/pool_layer.sv | 166 ++++++++++++++++
 tb/tb_pool_layer.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pool_pkg.sv
// pool_pkg: shared types and constants for the layer-1 max-pooling stage.
// Holds the pooling FSM state encoding, the memory select codes used on the
// shared csel-multiplexed memory port, and the default geometry/data widths.
package pool_pkg;

    localparam int IMG_W_DEFAULT = 64;
    localparam int DW_DEFAULT    = 20;
    localparam int AW_DEFAULT    = 12;

    localparam logic [2:0] CSEL_NONE  = 3'b000;
    localparam logic [2:0] CSEL_L0_K0 = 3'b001;
    localparam logic [2:0] CSEL_L0_K1 = 3'b010;
    localparam logic [2:0] CSEL_L1_K0 = 3'b011;
    localparam logic [2:0] CSEL_L1_K1 = 3'b100;
    localparam logic [2:0] CSEL_L2    = 3'b101;

    typedef enum logic [2:0] {
        IDLE,
        READ,
        LAST,
        WRITE,
        WRFL,
        DONE
    } state_t;

endpackage

// File: rtl/max_tracker.sv
// max_tracker: running signed maximum over the samples of one pooling window.
// Ports:
//   clk     - rising-edge clock
//   reset   - asynchronous active-low reset (clears the max to 0)
//   load    - take sample unconditionally (first sample of a window)
//   update  - take sample only if it is strictly greater (signed)
//   sample  - incoming DW-bit signed sample
//   max_val - registered running maximum
module max_tracker
    import pool_pkg::*;
#(
    parameter int DW = DW_DEFAULT
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          load,
    input  logic          update,
    input  logic [DW-1:0] sample,
    output logic [DW-1:0] max_val
);

    // Strictly-greater keeps the earlier sample on ties; the value is the same
    // either way, so ties never cause a spurious register update.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            max_val <= '0;
        end else if (load) begin
            max_val <= sample;
        end else if (update && ($signed(sample) > $signed(max_val))) begin
            max_val <= sample;
        end
    end

endmodule

// File: rtl/pool_layer.sv
// pool_layer: 2x2 max-pooling of both layer-0 channels into layer-1 memories.
// Reads every non-overlapping 2x2 window through the shared memory port,
// keeps the signed maximum and writes it to the pooled map of that channel.
// Optional feature macro: POOL_FLATTEN_EN - also writes each pooled value to
// the layer-2 flatten memory at interleaved address 2*idx+ch.
// Ports:
//   clk, reset (async active-low), start (level, sampled in IDLE)
//   busy, done           - pass status; done is a one-cycle pulse
//   crd, caddr_rd        - read strobe/address, cdata_rd returns one cycle later
//   cwr, caddr_wr, cdata_wr - write strobe/address/data
//   csel                 - memory select (000 when neither strobe is high)
module pool_layer
    import pool_pkg::*;
#(
    parameter int IMG_W = IMG_W_DEFAULT,
    parameter int DW    = DW_DEFAULT,
    parameter int AW    = AW_DEFAULT
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    output logic          busy,
    output logic          done,
    output logic          crd,
    output logic [AW-1:0] caddr_rd,
    input  logic [DW-1:0] cdata_rd,
    output logic          cwr,
    output logic [AW-1:0] caddr_wr,
    output logic [DW-1:0] cdata_wr,
    output logic [2:0]    csel
);

    localparam int PW = $clog2(IMG_W / 2);
    localparam int RW = $clog2(IMG_W);

    state_t        state, next_state;
    logic [1:0]    q, q_n;
    logic [PW-1:0] pr, pc, pr_n, pc_n;
    logic          ch, ch_n;
    logic          last_pix, advance;
    logic [AW-1:0] rd_addr_n, pix_idx_n, wr_addr_n;
    logic [2:0]    csel_n;

    assign last_pix = ch && (&pr) && (&pc);

`ifdef POOL_FLATTEN_EN
    assign advance = (state == WRFL);
`else
    assign advance = (state == WRITE);
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (start) next_state = READ;
            READ:    if (q == 2'd3) next_state = LAST;
            LAST:    next_state = WRITE;
`ifdef POOL_FLATTEN_EN
            WRITE:   next_state = WRFL;
            WRFL:    next_state = last_pix ? DONE : READ;
`else
            WRITE:   next_state = last_pix ? DONE : READ;
`endif
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Next values of the window counters. The outputs are registered, so the
    // address for a cycle is built from the counters that cycle will hold.
    always_comb begin
        q_n  = (state == READ) ? q + 2'd1 : 2'd0;
        pc_n = pc;
        pr_n = pr;
        ch_n = ch;
        if (state == IDLE) begin
            pc_n = '0;
            pr_n = '0;
            ch_n = 1'b0;
        end else if (advance) begin
            pc_n = pc + PW'(1);
            if (&pc) begin
                pr_n = pr + PW'(1);
                if (&pr) begin
                    ch_n = ~ch;
                end
            end
        end
    end

    // q[1] selects the lower row of the window, q[0] the right column, giving
    // the (0,0),(0,1),(1,0),(1,1) order as row*IMG_W+col.
    always_comb begin
        rd_addr_n = (AW'({pr_n, q_n[1]}) << RW) | AW'({pc_n, q_n[0]});
        pix_idx_n = (AW'(pr_n) << PW) | AW'(pc_n);
        wr_addr_n = '0;
        csel_n    = CSEL_NONE;
        case (next_state)
            READ: begin
                csel_n = ch_n ? CSEL_L0_K1 : CSEL_L0_K0;
            end
            WRITE: begin
                csel_n    = ch_n ? CSEL_L1_K1 : CSEL_L1_K0;
                wr_addr_n = pix_idx_n;
            end
`ifdef POOL_FLATTEN_EN
            WRFL: begin
                csel_n    = CSEL_L2;
                wr_addr_n = {pix_idx_n[AW-2:0], ch_n};
            end
`endif
            default: begin
                csel_n    = CSEL_NONE;
                wr_addr_n = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            q        <= '0;
            pr       <= '0;
            pc       <= '0;
            ch       <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            crd      <= 1'b0;
            cwr      <= 1'b0;
            caddr_rd <= '0;
            caddr_wr <= '0;
            csel     <= CSEL_NONE;
        end else begin
            q        <= q_n;
            pr       <= pr_n;
            pc       <= pc_n;
            ch       <= ch_n;
            busy     <= (next_state != IDLE);
            done     <= (next_state == DONE);
            crd      <= (next_state == READ);
            cwr      <= (next_state == WRITE) || (next_state == WRFL);
            caddr_rd <= (next_state == READ) ? rd_addr_n : '0;
            caddr_wr <= wr_addr_n;
            csel     <= csel_n;
        end
    end

    // Read data for sample q arrives while the FSM is at q+1 (or LAST for the
    // fourth sample), so the tracker strobes lag the read strobes by one cycle.
    max_tracker #(.DW(DW)) u_max (
        .clk    (clk),
        .reset  (reset),
        .load   ((state == READ) && (q == 2'd1)),
        .update (((state == READ) && (q >= 2'd2)) || (state == LAST)),
        .sample (cdata_rd),
        .max_val(cdata_wr)
    );

endmodule

// File: tb/tb_pool_layer.sv
module tb_pool_layer;
    import pool_pkg::*;

    localparam int IMG_W = 64;
    localparam int DW    = 20;
    localparam int AW    = 12;
    localparam int NPIX  = (IMG_W / 2) * (IMG_W / 2);
`ifdef POOL_FLATTEN_EN
    localparam int PIX_CYC = 7;
    localparam int EXP_L2  = 2 * NPIX;
`else
    localparam int PIX_CYC = 6;
    localparam int EXP_L2  = 0;
`endif
    localparam int PASS_CYC = 2 * NPIX * PIX_CYC + 1;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic          busy, done, crd, cwr;
    logic [AW-1:0] caddr_rd, caddr_wr;
    logic [DW-1:0] cdata_rd = '0;
    logic [DW-1:0] cdata_wr;
    logic [2:0]    csel;

    pool_layer #(.IMG_W(IMG_W), .DW(DW), .AW(AW)) dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .busy    (busy),
        .done    (done),
        .crd     (crd),
        .caddr_rd(caddr_rd),
        .cdata_rd(cdata_rd),
        .cwr     (cwr),
        .caddr_wr(caddr_wr),
        .cdata_wr(cdata_wr),
        .csel    (csel)
    );

    always #5 clk = ~clk;

    logic [DW-1:0] mem0 [0:1][0:IMG_W*IMG_W-1];
    logic [DW-1:0] l1   [0:1][0:NPIX-1];
    logic [DW-1:0] l2   [0:2*NPIX-1];

    int checks = 0;
    int passes = 0;

    // Monitor state
    logic          mon_on = 1'b0;
    int            cyc, n_rd, n_wr1, n_wr2, n_done, done_cyc;
    int            both_err, idle_sel_err, sel_err, order_err;
    logic [AW-1:0] first_rd [0:3];
    logic [2:0]    first_rd_sel;
    logic [AW-1:0] first_wr_addr;
    logic [DW-1:0] first_wr_data;

    // Layer-0 memory model: registered read, data valid the cycle after crd.
    always @(posedge clk) begin
        if (crd) begin
            if (csel == CSEL_L0_K0)      cdata_rd <= mem0[0][int'(caddr_rd)];
            else if (csel == CSEL_L0_K1) cdata_rd <= mem0[1][int'(caddr_rd)];
            else                         cdata_rd <= 'x;
        end
    end

    // Passive monitor sampling on the falling edge.
    always @(negedge clk) begin
        if (mon_on) begin
            int a;
            int c;
            cyc++;
            if (crd && cwr) both_err++;
            if (!crd && !cwr && csel != CSEL_NONE) idle_sel_err++;
            if (crd) begin
                if (csel != CSEL_L0_K0 && csel != CSEL_L0_K1) sel_err++;
                if (n_rd < 4) first_rd[n_rd] = caddr_rd;
                if (n_rd == 0) first_rd_sel = csel;
                n_rd++;
            end
            if (cwr) begin
                a = int'(caddr_wr);
                if (csel == CSEL_L1_K0 || csel == CSEL_L1_K1) begin
                    c = (csel == CSEL_L1_K1) ? 1 : 0;
                    if (a < NPIX) l1[c][a] = cdata_wr;
                    if (a != (n_wr1 % NPIX) || c != (n_wr1 / NPIX)) order_err++;
                    if (n_wr1 == 0) begin
                        first_wr_addr = caddr_wr;
                        first_wr_data = cdata_wr;
                    end
                    n_wr1++;
                end else if (csel == CSEL_L2) begin
                    if (a < 2 * NPIX) l2[a] = cdata_wr;
                    n_wr2++;
                end else begin
                    sel_err++;
                end
            end
            if (done) begin
                n_done++;
                done_cyc = cyc;
            end
        end
    end

    typedef struct {
        string         name;
        int            ch;
        int            addr;
        logic [DW-1:0] expv;
    } vec_t;

    vec_t vecs [0:5];

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic s);
        start = s;
        tick();
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual === expected) passes++;
        else $display("[TB] FAIL %s: got 0x%0h, required 0x%0h", name, actual, expected);
    endtask

    // Reference: maximum of the four samples of a window, signed.
    function automatic logic [DW-1:0] ref_max(input int c, input int pr, input int pc);
        logic signed [DW-1:0] best;
        logic signed [DW-1:0] v;
        best = mem0[c][(2 * pr) * IMG_W + 2 * pc];
        for (int dy = 0; dy < 2; dy++) begin
            for (int dx = 0; dx < 2; dx++) begin
                v = mem0[c][(2 * pr + dy) * IMG_W + 2 * pc + dx];
                if (v > best) best = v;
            end
        end
        return best;
    endfunction

    task automatic clear_monitor();
        cyc = 0; n_rd = 0; n_wr1 = 0; n_wr2 = 0; n_done = 0; done_cyc = 0;
        both_err = 0; idle_sel_err = 0; sel_err = 0; order_err = 0;
        first_wr_addr = '1; first_wr_data = '1; first_rd_sel = '0;
        for (int i = 0; i < 4; i++) first_rd[i] = '1;
    endtask

    initial begin
        logic [31:0] r;
        int          idle_act, bad, wr_in_rst, hit;

        reset = 1'b0;
        start = 1'b0;
        clear_monitor();

        for (int a = 0; a < IMG_W * IMG_W; a++) begin
            r = $urandom();
            mem0[0][a] = r[DW-1:0];
            mem0[1][a] = DW'(a);
        end
        for (int c = 0; c < 2; c++)
            for (int a = 0; a < NPIX; a++) l1[c][a] = 'x;
        for (int a = 0; a < 2 * NPIX; a++) l2[a] = 'x;
        // ch0 window (0,0) = {5,9,3,7}
        mem0[0][0] = 20'd5;  mem0[0][1] = 20'd9;  mem0[0][64] = 20'd3;  mem0[0][65] = 20'd7;
        // ch0 window (0,1): all ties
        mem0[0][2] = 20'h00010; mem0[0][3] = 20'h00010; mem0[0][66] = 20'h00010; mem0[0][67] = 20'h00010;
        // ch0 window (0,2): all zero
        mem0[0][4] = '0; mem0[0][5] = '0; mem0[0][68] = '0; mem0[0][69] = '0;
        // ch0 window (0,3): all negative, max is -2
        mem0[0][6] = 20'hFFFFB; mem0[0][7] = 20'hFFFFE; mem0[0][70] = 20'hFFFF7; mem0[0][71] = 20'hFFFF9;
        // ch1 pixel (0,1) carries 0x12345
        mem0[1][2] = 20'h12345;

        vecs[0] = '{"ch0_win00_max", 0, 0,    20'd9};
        vecs[1] = '{"ch0_ties",      0, 1,    20'h00010};
        vecs[2] = '{"ch0_zero",      0, 2,    20'h00000};
        vecs[3] = '{"ch0_negative",  0, 3,    20'hFFFFE};
        vecs[4] = '{"ch1_ramp_last", 1, 1023, 20'd4095};
        vecs[5] = '{"ch1_pix01",     1, 1,    20'h12345};

        // Reset held for 3 cycles, then released
        repeat (3) tick();
        checkOutput("in_reset_busy", busy, 0);
        reset = 1'b1;
        tick();
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_done", done, 0);
        checkOutput("rst_crd", crd, 0);
        checkOutput("rst_cwr", cwr, 0);
        checkOutput("rst_caddr_rd", caddr_rd, 0);
        checkOutput("rst_caddr_wr", caddr_wr, 0);
        checkOutput("rst_cdata_wr", cdata_wr, 0);
        checkOutput("rst_csel", csel, 0);

        idle_act = 0;
        repeat (100) begin
            tick();
            if (crd || cwr || busy) idle_act++;
        end
        checkOutput("idle_no_activity", idle_act, 0);

        // Full pass
        clear_monitor();
        mon_on = 1'b1;
        applyStimulus(1'b1);
        start = 1'b0;
        checkOutput("busy_after_start", busy, 1);
        for (int i = 0; i < PASS_CYC + 50 && n_done == 0; i++) tick();
        repeat (5) tick();
        mon_on = 1'b0;
        checkOutput("done_pulses_once", n_done, 1);
        checkOutput("done_cycle", done_cyc, PASS_CYC);
        checkOutput("busy_after_done", busy, 0);
        checkOutput("crd_cwr_overlap", both_err, 0);
        checkOutput("csel_idle_nonzero", idle_sel_err, 0);
        checkOutput("csel_illegal", sel_err, 0);
        checkOutput("write_order", order_err, 0);
        checkOutput("layer1_write_count", n_wr1, 2 * NPIX);
        checkOutput("layer2_write_count", n_wr2, EXP_L2);
        checkOutput("first_rd_csel", first_rd_sel, CSEL_L0_K0);
        checkOutput("first_rd0", first_rd[0], 0);
        checkOutput("first_rd1", first_rd[1], 1);
        checkOutput("first_rd2", first_rd[2], 64);
        checkOutput("first_rd3", first_rd[3], 65);

        for (int i = 0; i < 6; i++)
            checkOutput(vecs[i].name, l1[vecs[i].ch][vecs[i].addr], vecs[i].expv);

        for (int c = 0; c < 2; c++) begin
            bad = 0;
            for (int pr = 0; pr < IMG_W / 2; pr++)
                for (int pc = 0; pc < IMG_W / 2; pc++)
                    if (l1[c][pr * (IMG_W / 2) + pc] !== ref_max(c, pr, pc)) begin
                        if (bad == 0)
                            $display("[TB] first difference ch%0d (%0d,%0d): 0x%0h vs 0x%0h",
                                     c, pr, pc, l1[c][pr * (IMG_W / 2) + pc], ref_max(c, pr, pc));
                        bad++;
                    end
            checkOutput(c == 0 ? "model_layer1_ch0" : "model_layer1_ch1", bad, 0);
        end

`ifdef POOL_FLATTEN_EN
        checkOutput("flatten_addr3", l2[3], 20'h12345);
        bad = 0;
        for (int c = 0; c < 2; c++)
            for (int idx = 0; idx < NPIX; idx++)
                if (l2[2 * idx + c] !== ref_max(c, idx / (IMG_W / 2), idx % (IMG_W / 2))) bad++;
        checkOutput("model_layer2", bad, 0);
`endif

        // Reset in the middle of ch0 row 10
        applyStimulus(1'b1);
        start = 1'b0;
        hit = 0;
        for (int i = 0; i < 20000 && hit == 0; i++) begin
            tick();
            if (cwr && csel == CSEL_L1_K0 && caddr_wr == AW'(10 * 32 + 5)) hit = 1;
        end
        checkOutput("midpass_reached", hit, 1);
        reset = 1'b0;
        #1;
        checkOutput("abort_busy", busy, 0);
        checkOutput("abort_crd", crd, 0);
        checkOutput("abort_cwr", cwr, 0);
        checkOutput("abort_csel", csel, 0);
        checkOutput("abort_caddr_rd", caddr_rd, 0);
        checkOutput("abort_caddr_wr", caddr_wr, 0);
        checkOutput("abort_cdata_wr", cdata_wr, 0);
        wr_in_rst = 0;
        repeat (3) begin
            tick();
            if (cwr || crd) wr_in_rst++;
        end
        reset = 1'b1;
        repeat (5) begin
            tick();
            if (cwr || crd || busy) wr_in_rst++;
        end
        checkOutput("no_activity_after_abort", wr_in_rst, 0);

        clear_monitor();
        mon_on = 1'b1;
        applyStimulus(1'b1);
        start = 1'b0;
        for (int i = 0; i < 50 && n_wr1 == 0; i++) tick();
        mon_on = 1'b0;
        checkOutput("restart_rd0", first_rd[0], 0);
        checkOutput("restart_rd_csel", first_rd_sel, CSEL_L0_K0);
        checkOutput("restart_wr_addr", first_wr_addr, 0);
        checkOutput("restart_wr_data", first_wr_data, 20'd9);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
